mc_controller: RTL and testbench
================================

# mc_controller

Control unit for the multi-cycle RV64 datapath: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback. It decodes the IR contents and the ALU `zero` flag, and drives every datapath enable and mux select. It also stalls on a memory ready handshake. It sits directly upstream of the datapath, and its outputs connect one-to-one to the datapath control inputs.

## Interface
- No parameters.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst`  in  32  IR contents; uses `[6:0]` opcode, `[14:12]` funct3, `[30]` funct7b5.
- `zero`  in  1  combinational ALU zero flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pcen`, `IorD`, `MemWrite`, `MemRead`, `IRWrite`, `RegWrite`, `ALUSrcA`, `PCSrc`, `sw`  out  1 each  datapath controls.
- `MemtoReg`, `ALUSrcB`  out  2 each  datapath mux selects.
- `alu_ctrl`  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
- `illegal`  out  1  high while in TRAP.

## Operation
- **Mux semantics driven:**
  - `PCSrc` 0 = alu_result, 1 = alu_out.
  - `IorD` 0 = PC, 1 = alu_out.
  - `MemtoReg` 0 = alu_out, 1 = MDR, 2 = PC, 3 = sext(MDR[31:0]).
  - `ALUSrcA` 0 = PC, 1 = A.
  - `ALUSrcB` 0 = B, 1 = 4, 2 = imm, 3 = alu_out.
  - `sw` 1 = sext(B[31:0]).
- **Supported instructions:**
  - R-type (0110011): add, sub, and, or, slt.
  - addi (0010011, f3 000).
  - ld (f3 011) and lw (f3 010), opcode 0000011.
  - sd (f3 011) and sw (f3 010), opcode 0100011.
  - beq (f3 000) and bne (f3 001), opcode 1100011.
  - jal (1101111).
- **States.** Every output not listed for a state is 0.
  - FETCH: `MemRead`, IorD=0, `IRWrite`=`mem_ready`. Stay while `!mem_ready`, else go to DECODE.
  - DECODE: SrcA=0, SrcB=2, ADD, so alu_out = PC+imm. Dispatch on opcode; unsupported opcode or funct goes to TRAP.
  - EXEC_R: SrcA=1, SrcB=0, op from funct → ALU_WB.
  - EXEC_I: SrcA=1, SrcB=2, ADD → ALU_WB.
  - ALU_WB: `RegWrite`, MemtoReg=0; `pcen`, PCSrc=0, SrcA=0, SrcB=1, ADD (PC+4) → FETCH.
  - ADDR: SrcA=1, SrcB=2, ADD → MEM_RD for loads, MEM_WR for stores.
  - MEM_RD: `MemRead`, IorD=1, ALU held at A+imm (SrcA=1, SrcB=2, ADD) so alu_out stays stable. Stay while `!mem_ready`, else → LD_WB.
  - LD_WB: `RegWrite`, MemtoReg=1 for ld or 3 for lw; PC+4 as in ALU_WB → FETCH.
  - MEM_WR: `MemWrite`, IorD=1, `sw`=(f3==010), ALU held at A+imm. Stay while `!mem_ready`, else → PC_INC.
  - PC_INC: `pcen`, PCSrc=0, SrcA=0, SrcB=1, ADD → FETCH.
  - BR: SrcA=1, SrcB=0, SUB. Taken = `zero` for beq, `!zero` for bne. `pcen`=taken with PCSrc=1, loading the PC+imm target captured in DECODE. Taken → FETCH; not taken → PC_INC.
  - JAL1: `pcen`, PCSrc=1 (PC ← target). Same cycle: SrcA=0, SrcB=1, ADD, so alu_out ← old PC+4 → JAL2.
  - JAL2: `RegWrite`, MemtoReg=0 → FETCH.
  - TRAP: all enables 0, `illegal`=1. Held until reset.
- `MemRead` and `MemWrite` are never asserted together. `RegWrite` and `MemWrite` are never asserted together.

## Timing
- **Reset.**
  - `rst` low forces state FETCH asynchronously.
  - While `rst` is low, all outputs are forced to 0, including `MemRead` and `IRWrite`.
  - The first fetch request occurs in the first cycle after `rst` deasserts.
- **Latency with zero-wait memory** (`mem_ready`=1 in every memory state):
  - R/addi: 4 cycles.
  - ld/lw/sd/sw: 5 cycles.
  - beq/bne: 3 cycles taken, 4 not taken.
  - jal: 4 cycles.
- Each cycle of `mem_ready`=0 in a memory state adds exactly one cycle. Nothing else changes during the stall.
- **Mealy outputs.** `IRWrite` (FETCH) and `pcen` (BR) depend combinationally on inputs. All other outputs decode from state only.
- **Reset mid-instruction.** Aborts the instruction and returns to FETCH. Any register or memory write already committed at an earlier edge stands.

## Structure
- **Package `rv_mc_pkg`:** state enum, opcode constants, funct3 constants, `alu_ctrl` encodings, and the mux select constants for `MemtoReg`, `ALUSrcB` and `IorD`.
- **Sub-module `alu_decoder`:** combinational; maps funct3/funct7b5 to `alu_ctrl` plus a `valid` flag.
- **Top:** a state register plus next-state and output logic.

## Test plan
- Reset, then `inst`=add x3,x1,x2 (0x002081B3), `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALU_WB. `alu_ctrl`=0010 in EXEC_R; `RegWrite` and `pcen` high in cycle 4 only.
- sub (funct7b5=1) → `alu_ctrl`=0110. slt → 0111. funct3=001 R-type → TRAP, `illegal`=1 persisting across 10 cycles.
- lw with `mem_ready` low for 3 MEM_RD cycles → 8 total cycles. IorD=1 throughout MEM_RD. LD_WB drives MemtoReg=3. `MemWrite` never high.
- sw → MEM_WR with `sw`=1 and `MemWrite`=1, then PC_INC with `pcen`=1 and SrcB=1. sd gives the same sequence with `sw`=0.
- beq: `zero`=1 → `pcen`=1, PCSrc=1 in BR, 3 cycles. `zero`=0 → PC_INC, 4 cycles. bne with `zero`=0 is taken.
- jal → JAL1 with `pcen`=1, PCSrc=1, SrcB=1; JAL2 with `RegWrite`=1, MemtoReg=0. Asserting `rst` low during JAL1 → all outputs 0 immediately, FETCH after release.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// ============================================================================
//  Module      : rv_mc_pkg
//  Description : Shared types and constants for the multi-cycle RV64 control
//                unit: FSM state encoding, opcode/funct3 values, ALU control
//                codes and datapath mux select values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_mc_pkg;

   // Controller states; 14 used codes out of 16, spare codes fall into TRAP
   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_EXEC_I = 4'd3,
      ST_ALU_WB = 4'd4,
      ST_ADDR   = 4'd5,
      ST_MEM_RD = 4'd6,
      ST_LD_WB  = 4'd7,
      ST_MEM_WR = 4'd8,
      ST_PC_INC = 4'd9,
      ST_BR     = 4'd10,
      ST_JAL1   = 4'd11,
      ST_JAL2   = 4'd12,
      ST_TRAP   = 4'd13
   } state_e;

   // Major opcodes
   localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] C_OP_IMM    = 7'b0010011;
   localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] C_OP_STORE  = 7'b0100011;
   localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] C_OP_JAL    = 7'b1101111;

   // funct3 values
   localparam logic [2:0] C_F3_ADD_SUB = 3'b000;
   localparam logic [2:0] C_F3_SLT     = 3'b010;
   localparam logic [2:0] C_F3_OR      = 3'b110;
   localparam logic [2:0] C_F3_AND     = 3'b111;
   localparam logic [2:0] C_F3_ADDI    = 3'b000;
   localparam logic [2:0] C_F3_BEQ     = 3'b000;
   localparam logic [2:0] C_F3_BNE     = 3'b001;
   localparam logic [2:0] C_F3_WORD    = 3'b010;
   localparam logic [2:0] C_F3_DWORD   = 3'b011;

   // ALU operation codes
   localparam logic [3:0] C_ALU_AND = 4'b0000;
   localparam logic [3:0] C_ALU_OR  = 4'b0001;
   localparam logic [3:0] C_ALU_ADD = 4'b0010;
   localparam logic [3:0] C_ALU_SUB = 4'b0110;
   localparam logic [3:0] C_ALU_SLT = 4'b0111;

   // Writeback source select
   localparam logic [1:0] C_M2R_ALUOUT   = 2'd0;
   localparam logic [1:0] C_M2R_MDR      = 2'd1;
   localparam logic [1:0] C_M2R_PC       = 2'd2;
   localparam logic [1:0] C_M2R_MDR_SEXT = 2'd3;

   // ALU operand B select
   localparam logic [1:0] C_SRCB_B      = 2'd0;
   localparam logic [1:0] C_SRCB_FOUR   = 2'd1;
   localparam logic [1:0] C_SRCB_IMM    = 2'd2;
   localparam logic [1:0] C_SRCB_ALUOUT = 2'd3;

   // ALU operand A select
   localparam logic C_SRCA_PC = 1'b0;
   localparam logic C_SRCA_A  = 1'b1;

   // Memory address select
   localparam logic C_IORD_PC     = 1'b0;
   localparam logic C_IORD_ALUOUT = 1'b1;

   // PC source select
   localparam logic C_PCSRC_ALU    = 1'b0;
   localparam logic C_PCSRC_ALUOUT = 1'b1;

   // Loads/stores only come in word and doubleword widths here
   function automatic logic is_mem_width(input logic [2:0] f3);
      return (f3 == C_F3_WORD) || (f3 == C_F3_DWORD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps R-type funct3/funct7b5 to an ALU control code and flags
//                whether the combination is one this core implements.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
   import rv_mc_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_ctrl,
   output logic       valid
);

   // funct7b5 only selects SUB over ADD; on any other funct3 it marks an
   // unsupported instruction
   always_comb begin
      alu_ctrl = C_ALU_ADD;
      valid    = 1'b0;
      case (funct3)
         C_F3_ADD_SUB: begin
            alu_ctrl = funct7b5 ? C_ALU_SUB : C_ALU_ADD;
            valid    = 1'b1;
         end
         C_F3_SLT: begin
            alu_ctrl = C_ALU_SLT;
            valid    = !funct7b5;
         end
         C_F3_OR: begin
            alu_ctrl = C_ALU_OR;
            valid    = !funct7b5;
         end
         C_F3_AND: begin
            alu_ctrl = C_ALU_AND;
            valid    = !funct7b5;
         end
         default: begin
            alu_ctrl = C_ALU_ADD;
            valid    = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
//  Module      : mc_controller
//  Description : Multi-cycle RV64 control FSM. Sequences fetch, decode,
//                execute, memory and writeback, stalls on mem_ready and drives
//                every datapath enable and mux select.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller
   import rv_mc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pcen,
   output logic        IorD,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic        PCSrc,
   output logic        sw,
   output logic [1:0]  MemtoReg,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  alu_ctrl,
   output logic        illegal
);

   state_e      state_q;
   state_e      state_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic [3:0]  r_alu_ctrl;
   logic        r_alu_valid;
   logic        br_taken;
   logic        unused_inst_bits;

   assign opcode   = inst[6:0];
   assign funct3   = inst[14:12];
   assign funct7b5 = inst[30];

   // Register numbers and immediates belong to the datapath, not to control
   assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

   // beq takes on equality, bne on inequality; funct3[0] tells them apart
   assign br_taken = funct3[0] ? !zero : zero;

   alu_decoder u_alu_decoder (
      .funct3   (funct3),
      .funct7b5 (funct7b5),
      .alu_ctrl (r_alu_ctrl),
      .valid    (r_alu_valid)
   );

   // State register; reset lands in FETCH so the first fetch follows release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: dispatch in DECODE, hold in memory states until mem_ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               C_OP_RTYPE:  state_d = r_alu_valid ? ST_EXEC_R : ST_TRAP;
               C_OP_IMM:    state_d = (funct3 == C_F3_ADDI) ? ST_EXEC_I : ST_TRAP;
               C_OP_LOAD,
               C_OP_STORE:  state_d = is_mem_width(funct3) ? ST_ADDR : ST_TRAP;
               C_OP_BRANCH: state_d = ((funct3 == C_F3_BEQ) || (funct3 == C_F3_BNE))
                                      ? ST_BR : ST_TRAP;
               C_OP_JAL:    state_d = ST_JAL1;
               default:     state_d = ST_TRAP;
            endcase
         end
         ST_EXEC_R: state_d = ST_ALU_WB;
         ST_EXEC_I: state_d = ST_ALU_WB;
         ST_ALU_WB: state_d = ST_FETCH;
         ST_ADDR:   state_d = (opcode == C_OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
         ST_MEM_RD: state_d = mem_ready ? ST_LD_WB : ST_MEM_RD;
         ST_LD_WB:  state_d = ST_FETCH;
         ST_MEM_WR: state_d = mem_ready ? ST_PC_INC : ST_MEM_WR;
         ST_PC_INC: state_d = ST_FETCH;
         ST_BR:     state_d = br_taken ? ST_FETCH : ST_PC_INC;
         ST_JAL1:   state_d = ST_JAL2;
         ST_JAL2:   state_d = ST_FETCH;
         ST_TRAP:   state_d = ST_TRAP;
         default:   state_d = ST_TRAP;
      endcase
   end

   // Output decode from state; IRWrite and pcen in BR also follow inputs.
   // Everything is held at 0 while reset is asserted, even in FETCH.
   always_comb begin
      pcen     = 1'b0;
      IorD     = C_IORD_PC;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = C_SRCA_PC;
      PCSrc    = C_PCSRC_ALU;
      sw       = 1'b0;
      MemtoReg = C_M2R_ALUOUT;
      ALUSrcB  = C_SRCB_B;
      alu_ctrl = C_ALU_AND;
      illegal  = 1'b0;
      if (rst) begin
         case (state_q)
            ST_FETCH: begin
               MemRead = 1'b1;
               IorD    = C_IORD_PC;
               IRWrite = mem_ready;
            end
            ST_DECODE: begin
               // alu_out <- PC + imm, used later as branch/jump target
               ALUSrcA  = C_SRCA_PC;
               ALUSrcB  = C_SRCB_IMM;
               alu_ctrl = C_ALU_ADD;
            end
            ST_EXEC_R: begin
               ALUSrcA  = C_SRCA_A;
               ALUSrcB  = C_SRCB_B;
               alu_ctrl = r_alu_ctrl;
            end
            ST_EXEC_I, ST_ADDR: begin
               ALUSrcA  = C_SRCA_A;
               ALUSrcB  = C_SRCB_IMM;
               alu_ctrl = C_ALU_ADD;
            end
            ST_ALU_WB: begin
               RegWrite = 1'b1;
               MemtoReg = C_M2R_ALUOUT;
               pcen     = 1'b1;
               PCSrc    = C_PCSRC_ALU;
               ALUSrcA  = C_SRCA_PC;
               ALUSrcB  = C_SRCB_FOUR;
               alu_ctrl = C_ALU_ADD;
            end
            ST_MEM_RD: begin
               // Keep recomputing A+imm so alu_out is stable across stalls
               MemRead  = 1'b1;
               IorD     = C_IORD_ALUOUT;
               ALUSrcA  = C_SRCA_A;
               ALUSrcB  = C_SRCB_IMM;
               alu_ctrl = C_ALU_ADD;
            end
            ST_LD_WB: begin
               RegWrite = 1'b1;
               MemtoReg = (funct3 == C_F3_DWORD) ? C_M2R_MDR : C_M2R_MDR_SEXT;
               pcen     = 1'b1;
               PCSrc    = C_PCSRC_ALU;
               ALUSrcA  = C_SRCA_PC;
               ALUSrcB  = C_SRCB_FOUR;
               alu_ctrl = C_ALU_ADD;
            end
            ST_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = C_IORD_ALUOUT;
               sw       = (funct3 == C_F3_WORD);
               ALUSrcA  = C_SRCA_A;
               ALUSrcB  = C_SRCB_IMM;
               alu_ctrl = C_ALU_ADD;
            end
            ST_PC_INC: begin
               pcen     = 1'b1;
               PCSrc    = C_PCSRC_ALU;
               ALUSrcA  = C_SRCA_PC;
               ALUSrcB  = C_SRCB_FOUR;
               alu_ctrl = C_ALU_ADD;
            end
            ST_BR: begin
               // Compare A-B; a taken branch loads the target held in alu_out
               ALUSrcA  = C_SRCA_A;
               ALUSrcB  = C_SRCB_B;
               alu_ctrl = C_ALU_SUB;
               PCSrc    = C_PCSRC_ALUOUT;
               pcen     = br_taken;
            end
            ST_JAL1: begin
               // PC <- target while the ALU forms the link value old PC+4
               pcen     = 1'b1;
               PCSrc    = C_PCSRC_ALUOUT;
               ALUSrcA  = C_SRCA_PC;
               ALUSrcB  = C_SRCB_FOUR;
               alu_ctrl = C_ALU_ADD;
            end
            ST_JAL2: begin
               RegWrite = 1'b1;
               MemtoReg = C_M2R_ALUOUT;
            end
            ST_TRAP: begin
               illegal = 1'b1;
            end
            default: begin
               illegal = 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Scoreboard bench for mc_controller. Each driven cycle pushes
//                the hand-derived expected output vector; a monitor pops and
//                compares on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

   logic        clk;
   logic        rst;
   logic [31:0] inst;
   logic        zero;
   logic        mem_ready;
   logic        pcen, IorD, MemWrite, MemRead, IRWrite, RegWrite;
   logic        ALUSrcA, PCSrc, sw, illegal;
   logic [1:0]  MemtoReg, ALUSrcB;
   logic [3:0]  alu_ctrl;

   logic [17:0] got;
   logic [17:0] exp_q[$];
   string       name_q[$];
   int          total;
   int          bad;

   // Instruction encodings
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;
   localparam logic [31:0] I_AND  = 32'h0020F1B3;
   localparam logic [31:0] I_OR   = 32'h0020E1B3;
   localparam logic [31:0] I_SLL  = 32'h002091B3;
   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_LW   = 32'h0000A283;
   localparam logic [31:0] I_LD   = 32'h0000B283;
   localparam logic [31:0] I_SW   = 32'h0050A023;
   localparam logic [31:0] I_SD   = 32'h0050B023;
   localparam logic [31:0] I_BEQ  = 32'h00208063;
   localparam logic [31:0] I_BNE  = 32'h00209063;
   localparam logic [31:0] I_JAL  = 32'h000000EF;
   localparam logic [31:0] I_LUI  = 32'h000000B7;

   mc_controller dut (
      .clk       (clk),
      .rst       (rst),
      .inst      (inst),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pcen      (pcen),
      .IorD      (IorD),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .IRWrite   (IRWrite),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .PCSrc     (PCSrc),
      .sw        (sw),
      .MemtoReg  (MemtoReg),
      .ALUSrcB   (ALUSrcB),
      .alu_ctrl  (alu_ctrl),
      .illegal   (illegal)
   );

   assign got = {pcen, IorD, MemWrite, MemRead, IRWrite, RegWrite, ALUSrcA,
                 PCSrc, sw, MemtoReg, ALUSrcB, alu_ctrl, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector order matches 'got'
   function automatic logic [17:0] pk(input logic pc, io, mw, mr, irw, rw, sa, ps, s,
                                      input logic [1:0] m2r, sb,
                                      input logic [3:0] alu, input logic ill);
      return {pc, io, mw, mr, irw, rw, sa, ps, s, m2r, sb, alu, ill};
   endfunction

   // Expected outputs per state, written out from the state table
   function automatic logic [17:0] e_fetch(input logic mr);
      return pk(0,0,0,1,mr,0,0,0,0, 2'd0, 2'd0, 4'b0000, 0);
   endfunction
   function automatic logic [17:0] e_decode();
      return pk(0,0,0,0,0,0,0,0,0, 2'd0, 2'd2, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_exec_r(input logic [3:0] alu);
      return pk(0,0,0,0,0,0,1,0,0, 2'd0, 2'd0, alu, 0);
   endfunction
   function automatic logic [17:0] e_exec_i();
      return pk(0,0,0,0,0,0,1,0,0, 2'd0, 2'd2, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_alu_wb();
      return pk(1,0,0,0,0,1,0,0,0, 2'd0, 2'd1, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_addr();
      return pk(0,0,0,0,0,0,1,0,0, 2'd0, 2'd2, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_mem_rd();
      return pk(0,1,0,1,0,0,1,0,0, 2'd0, 2'd2, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_ld_wb(input logic [1:0] m2r);
      return pk(1,0,0,0,0,1,0,0,0, m2r, 2'd1, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_mem_wr(input logic swb);
      return pk(0,1,1,0,0,0,1,0,swb, 2'd0, 2'd2, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_pc_inc();
      return pk(1,0,0,0,0,0,0,0,0, 2'd0, 2'd1, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_br(input logic taken);
      return pk(taken,0,0,0,0,0,1,1,0, 2'd0, 2'd0, 4'b0110, 0);
   endfunction
   function automatic logic [17:0] e_jal1();
      return pk(1,0,0,0,0,0,0,1,0, 2'd0, 2'd1, 4'b0010, 0);
   endfunction
   function automatic logic [17:0] e_jal2();
      return pk(0,0,0,0,0,1,0,0,0, 2'd0, 2'd0, 4'b0000, 0);
   endfunction
   function automatic logic [17:0] e_trap();
      return pk(0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 4'b0000, 1);
   endfunction

   // One clock cycle: drive inputs just after the rising edge and queue the
   // outputs the DUT must show for the rest of that cycle
   task automatic cyc(input logic r, input logic [31:0] ins, input logic z,
                      input logic mr, input logic [17:0] e, input string nm);
      @(posedge clk);
      #1;
      rst       = r;
      inst      = ins;
      zero      = z;
      mem_ready = mr;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic run_r(input logic [31:0] ins, input logic [3:0] alu, input string tag);
      cyc(1, ins, 0, 1, e_fetch(1), {tag, ".fetch"});
      cyc(1, ins, 0, 1, e_decode(), {tag, ".decode"});
      cyc(1, ins, 0, 1, e_exec_r(alu), {tag, ".exec_r"});
      cyc(1, ins, 0, 1, e_alu_wb(), {tag, ".alu_wb"});
   endtask

   task automatic run_br(input logic [31:0] ins, input logic z, input logic taken,
                         input string tag);
      cyc(1, ins, 0, 1, e_fetch(1), {tag, ".fetch"});
      cyc(1, ins, 0, 1, e_decode(), {tag, ".decode"});
      cyc(1, ins, z, 1, e_br(taken), {tag, ".br"});
      if (!taken) cyc(1, ins, 0, 1, e_pc_inc(), {tag, ".pc_inc"});
   endtask

   // Monitor: compare every queued expectation on the falling edge
   initial begin : p_monitor
      logic [17:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL %s: got=%05h expected=%05h", nm, got, e);
            end
         end
      end
   end

   initial begin : p_stim
      total     = 0;
      bad       = 0;
      rst       = 1'b0;
      inst      = 32'h0;
      zero      = 1'b0;
      mem_ready = 1'b1;

      // Reset holds everything low, including MemRead in FETCH
      cyc(0, 32'h0, 0, 1, 18'h0, "reset0");
      cyc(0, I_ADD, 1, 1, 18'h0, "reset1");

      run_r(I_ADD, 4'b0010, "add");
      run_r(I_SUB, 4'b0110, "sub");
      run_r(I_SLT, 4'b0111, "slt");
      run_r(I_AND, 4'b0000, "and");
      run_r(I_OR,  4'b0001, "or");

      cyc(1, I_ADDI, 0, 1, e_fetch(1), "addi.fetch");
      cyc(1, I_ADDI, 0, 1, e_decode(), "addi.decode");
      cyc(1, I_ADDI, 0, 1, e_exec_i(), "addi.exec_i");
      cyc(1, I_ADDI, 0, 1, e_alu_wb(), "addi.alu_wb");

      // lw with three wait cycles in MEM_RD: 8 cycles total
      cyc(1, I_LW, 0, 1, e_fetch(1), "lw.fetch");
      cyc(1, I_LW, 0, 1, e_decode(), "lw.decode");
      cyc(1, I_LW, 0, 1, e_addr(),   "lw.addr");
      cyc(1, I_LW, 0, 0, e_mem_rd(), "lw.mem_rd_wait0");
      cyc(1, I_LW, 0, 0, e_mem_rd(), "lw.mem_rd_wait1");
      cyc(1, I_LW, 0, 0, e_mem_rd(), "lw.mem_rd_wait2");
      cyc(1, I_LW, 0, 1, e_mem_rd(), "lw.mem_rd");
      cyc(1, I_LW, 0, 1, e_ld_wb(2'd3), "lw.ld_wb");

      // ld with one wait cycle in FETCH (IRWrite low while waiting)
      cyc(1, I_LD, 0, 0, e_fetch(0), "ld.fetch_wait");
      cyc(1, I_LD, 0, 1, e_fetch(1), "ld.fetch");
      cyc(1, I_LD, 0, 1, e_decode(), "ld.decode");
      cyc(1, I_LD, 0, 1, e_addr(),   "ld.addr");
      cyc(1, I_LD, 0, 1, e_mem_rd(), "ld.mem_rd");
      cyc(1, I_LD, 0, 1, e_ld_wb(2'd1), "ld.ld_wb");

      cyc(1, I_SW, 0, 1, e_fetch(1),   "sw.fetch");
      cyc(1, I_SW, 0, 1, e_decode(),   "sw.decode");
      cyc(1, I_SW, 0, 1, e_addr(),     "sw.addr");
      cyc(1, I_SW, 0, 1, e_mem_wr(1),  "sw.mem_wr");
      cyc(1, I_SW, 0, 1, e_pc_inc(),   "sw.pc_inc");

      cyc(1, I_SD, 0, 1, e_fetch(1),   "sd.fetch");
      cyc(1, I_SD, 0, 1, e_decode(),   "sd.decode");
      cyc(1, I_SD, 0, 1, e_addr(),     "sd.addr");
      cyc(1, I_SD, 0, 0, e_mem_wr(0),  "sd.mem_wr_wait");
      cyc(1, I_SD, 0, 1, e_mem_wr(0),  "sd.mem_wr");
      cyc(1, I_SD, 0, 1, e_pc_inc(),   "sd.pc_inc");

      run_br(I_BEQ, 1, 1, "beq_taken");
      run_br(I_BEQ, 0, 0, "beq_not_taken");
      run_br(I_BNE, 0, 1, "bne_taken");
      run_br(I_BNE, 1, 0, "bne_not_taken");

      cyc(1, I_JAL, 0, 1, e_fetch(1), "jal.fetch");
      cyc(1, I_JAL, 0, 1, e_decode(), "jal.decode");
      cyc(1, I_JAL, 0, 1, e_jal1(),   "jal.jal1");
      cyc(1, I_JAL, 0, 1, e_jal2(),   "jal.jal2");

      // Reset asserted in JAL1 aborts the jump; fetch resumes after release
      cyc(1, I_JAL, 0, 1, e_fetch(1), "jalrst.fetch");
      cyc(1, I_JAL, 0, 1, e_decode(), "jalrst.decode");
      cyc(0, I_JAL, 0, 1, 18'h0,      "jalrst.in_reset");
      cyc(1, I_ADD, 0, 1, e_fetch(1), "jalrst.refetch");
      cyc(1, I_ADD, 0, 1, e_decode(), "jalrst.add_decode");
      cyc(1, I_ADD, 0, 1, e_exec_r(4'b0010), "jalrst.add_exec_r");
      cyc(1, I_ADD, 0, 1, e_alu_wb(), "jalrst.add_alu_wb");

      // Unsupported R-type funct3 traps and stays trapped regardless of inputs
      cyc(1, I_SLL, 0, 1, e_fetch(1), "sll.fetch");
      cyc(1, I_SLL, 0, 1, e_decode(), "sll.decode");
      for (int i = 0; i < 10; i++) begin
         cyc(1, (i % 2 == 0) ? I_ADD : I_SLL, i[0], i[1], e_trap(),
             $sformatf("sll.trap%0d", i));
      end
      cyc(0, I_LUI, 0, 1, 18'h0,      "trap_reset");

      // Unsupported opcode also traps
      cyc(1, I_LUI, 0, 1, e_fetch(1), "lui.fetch");
      cyc(1, I_LUI, 0, 1, e_decode(), "lui.decode");
      cyc(1, I_LUI, 0, 1, e_trap(),   "lui.trap");
      cyc(0, I_LUI, 0, 1, 18'h0,      "final_reset");

      // Let the monitor drain the queue
      @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
